reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_sb.sv | 87 ++++++++
 tb/tb_reg_file_sb.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with per-register busy scoreboard and pending counter.
// Latency: reads are combinational (0 cycles); writeback, issue and flush take effect at the next rising clk edge.
// Backpressure: none, every request is accepted. Define REG_FILE_SB_BYPASS_EN to forward same-cycle writeback to reads.
module reg_file_sb #(
  parameter int XLEN    = 32,
  parameter int AW      = 5,
  parameter int SP_IDX  = 2,
  parameter int SP_INIT = 128
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic            RegWrite,
  input  logic [AW-1:0]   target_reg,
  input  logic [XLEN-1:0] RegWrite_data,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic [XLEN-1:0] RegRead_data1,
  output logic [XLEN-1:0] RegRead_data2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic [AW:0]     pend_cnt
);

  localparam int NREG = 2 ** AW;

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     pend_cnt_q, pend_cnt_d;
  logic            wr_en, iss_en;

  assign wr_en  = RegWrite && (target_reg != '0);
  assign iss_en = issue_valid && (issue_rd != '0) && !flush;

  // Issue is applied after writeback so a same-register collision leaves busy set;
  // flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[target_reg] = 1'b0;
    if (flush) busy_d = '0;
    else if (iss_en) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt_d = pend_cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= (i == SP_IDX) ? XLEN'(SP_INIT) : '0;
      end
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      if (wr_en) regs_q[target_reg] <= RegWrite_data;
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  always_comb begin
    RegRead_data1 = (rs1 == '0) ? '0 : regs_q[rs1];
    RegRead_data2 = (rs2 == '0) ? '0 : regs_q[rs2];
    rs1_busy      = busy_q[rs1];
    rs2_busy      = busy_q[rs2];
`ifdef REG_FILE_SB_BYPASS_EN
    if (wr_en && (target_reg == rs1)) begin
      RegRead_data1 = RegWrite_data;
      rs1_busy      = 1'b0;
    end
    if (wr_en && (target_reg == rs2)) begin
      RegRead_data2 = RegWrite_data;
      rs2_busy      = 1'b0;
    end
`endif
  end

  assign pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb: reset values, scoreboard, collision, flush, x0, bypass and async reset.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, target_reg, issue_rd;
  logic        RegWrite, issue_valid, flush;
  logic [31:0] RegWrite_data;
  logic [31:0] RegRead_data1, RegRead_data2;
  logic        rs1_busy, rs2_busy;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.XLEN(32), .AW(5), .SP_IDX(2), .SP_INIT(128)) dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .RegWrite(RegWrite),
    .target_reg(target_reg), .RegWrite_data(RegWrite_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .RegRead_data1(RegRead_data1),
    .RegRead_data2(RegRead_data2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 1'b0; issue_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; rs1 = 5'd2; rs2 = 5'd5; target_reg = '0; issue_rd = '0;
    RegWrite = 1'b0; issue_valid = 1'b0; flush = 1'b0; RegWrite_data = '0;
    #12;
    check("rst_sp_in_reset", RegRead_data1, 32'd128);
    check("rst_pend_in_reset", 32'(pend_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("rst_sp", RegRead_data1, 32'd128);
    check("rst_x5", RegRead_data2, 32'd0);
    check("rst_pend", 32'(pend_cnt), 32'd0);

    // scoreboard
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    idle(); rs1 = 5'd7;
    #1;
    check("sb_busy", 32'(rs1_busy), 32'd1);
    check("sb_pend1", 32'(pend_cnt), 32'd1);
    RegWrite = 1'b1; target_reg = 5'd7; RegWrite_data = 32'hDEADBEEF;
    tick();
    idle();
    #1;
    check("sb_clear", 32'(rs1_busy), 32'd0);
    check("sb_data", RegRead_data1, 32'hDEADBEEF);
    check("sb_pend0", 32'(pend_cnt), 32'd0);

    // collision: issue wins over writeback on busy
    issue_valid = 1'b1; issue_rd = 5'd3;
    RegWrite = 1'b1; target_reg = 5'd3; RegWrite_data = 32'h55;
    tick();
    idle(); rs1 = 5'd3;
    #1;
    check("col_data", RegRead_data1, 32'h55);
    check("col_busy", 32'(rs1_busy), 32'd1);
    check("col_pend", 32'(pend_cnt), 32'd1);

    // flush
    issue_valid = 1'b1; issue_rd = 5'd4; tick();
    issue_rd = 5'd5; tick();
    issue_rd = 5'd6; tick();
    idle();
    #1;
    check("fl_pend4", 32'(pend_cnt), 32'd4);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd8;
    RegWrite = 1'b1; target_reg = 5'd10; RegWrite_data = 32'hA5;
    tick();
    idle(); rs1 = 5'd8; rs2 = 5'd4;
    #1;
    check("fl_busy8", 32'(rs1_busy), 32'd0);
    check("fl_busy4", 32'(rs2_busy), 32'd0);
    check("fl_pend0", 32'(pend_cnt), 32'd0);
    rs2 = 5'd10;
    #1;
    check("fl_wb_data", RegRead_data2, 32'hA5);

    // re-issue of a busy register and writeback to an idle one leave the count alone
    issue_valid = 1'b1; issue_rd = 5'd7; tick();
    tick();
    idle();
    RegWrite = 1'b1; target_reg = 5'd11; RegWrite_data = 32'h11;
    tick();
    idle();
    #1;
    check("reissue_pend", 32'(pend_cnt), 32'd1);

    // x0 is hardwired
    issue_valid = 1'b1; issue_rd = 5'd0;
    RegWrite = 1'b1; target_reg = 5'd0; RegWrite_data = 32'hFFFFFFFF;
    tick();
    idle(); rs1 = 5'd0;
    #1;
    check("x0_data", RegRead_data1, 32'd0);
    check("x0_busy", 32'(rs1_busy), 32'd0);
    check("x0_pend", 32'(pend_cnt), 32'd1);

    // same-cycle read of a register being written
    issue_valid = 1'b1; issue_rd = 5'd9; tick();
    idle();
    rs2 = 5'd9; RegWrite = 1'b1; target_reg = 5'd9; RegWrite_data = 32'h1234;
    #1;
`ifdef REG_FILE_SB_BYPASS_EN
    check("byp_data", RegRead_data2, 32'h1234);
    check("byp_busy", 32'(rs2_busy), 32'd0);
`else
    check("byp_data", RegRead_data2, 32'd0);
    check("byp_busy", 32'(rs2_busy), 32'd1);
`endif
    tick();
    idle();
    #1;
    check("byp_after_data", RegRead_data2, 32'h1234);
    check("byp_after_pend", 32'(pend_cnt), 32'd1);

    // asynchronous reset mid-cycle with a pending write
    rs1 = 5'd2; rs2 = 5'd10;
    RegWrite = 1'b1; target_reg = 5'd10; RegWrite_data = 32'h77;
    issue_valid = 1'b1; issue_rd = 5'd12;
    #2;
    reset = 1'b0;
    #1;
    check("arst_pend", 32'(pend_cnt), 32'd0);
    check("arst_x10", RegRead_data2, 32'd0);
    check("arst_sp", RegRead_data1, 32'd128);
    tick();
    @(negedge clk);
    reset = 1'b1;
    idle();
    rs1 = 5'd12;
    tick();
    check("arst_drop_wr", RegRead_data2, 32'd0);
    check("arst_drop_iss", 32'(rs1_busy), 32'd0);
    check("arst_pend_after", 32'(pend_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
